// File: rtl/bram_pkg.sv
// bram_pkg: shared constants, FSM encoding and lane helper for the dual-port BRAM
package bram_pkg;
  localparam bit RDW_READ_FIRST = 1'b0;
  localparam bit RDW_WRITE_FIRST = 1'b1;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;
  function automatic int lanes(input int width, input int lane);
    return width / lane;
  endfunction
endpackage

// File: rtl/bram_port_pipe.sv
// bram_port_pipe: per-port read pipeline (1 or 2 stages) with out-of-range zeroing
// Ports: clk, rst (async, active-low); v_in/oor/d_in = accepted request, address
// out of range, raw array word; dout/valid = registered read data and strobe.
module bram_port_pipe
  import bram_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int WIDTH = 128
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             v_in,
  input  logic             oor,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] dout,
  output logic             valid
);
  logic             v_m;
  logic [WIDTH-1:0] d_m;
  if (RD_LAT == 2) begin : g_l2
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        v_m <= 1'b0;
        d_m <= '0;
      end else begin
        v_m <= v_in;
        d_m <= oor ? '0 : d_in;
      end
  end else begin : g_l1
    assign v_m = v_in;
    assign d_m = oor ? '0 : d_in;
  end
  // dout only moves on a valid, so it holds between requests
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      valid <= 1'b0;
      dout <= '0;
    end else begin
      valid <= v_m;
      if (v_m) dout <= d_m;
    end
endmodule

// File: rtl/bram_tdp_ctrl.sv
// bram_tdp_ctrl: true dual-port block memory with lane enables, clear sequencer and read strobes
// Ports: clk, rst (async, active-low); ready = array usable; per port x in {a,b}:
// x_en request, x_we lane write enables (0 = read), x_addr, x_din, x_dout, x_valid.
module bram_tdp_ctrl
  import bram_pkg::*;
#(
  parameter int    WIDTH = 128,
  parameter int    DEPTH = 1024,
  parameter int    ADDR = 10,
  parameter int    LANE = 8,
  parameter int    RD_LAT = 1,
  parameter bit    RDW_MODE = RDW_READ_FIRST,
  parameter bit    CLR_ON_RST = 1'b1,
  parameter string FILE = ""
)(
  input  logic                          clk,
  input  logic                          rst,
  output logic                          ready,
  input  logic                          a_en,
  input  logic [lanes(WIDTH,LANE)-1:0]  a_we,
  input  logic [ADDR-1:0]               a_addr,
  input  logic [WIDTH-1:0]              a_din,
  output logic [WIDTH-1:0]              a_dout,
  output logic                          a_valid,
  input  logic                          b_en,
  input  logic [lanes(WIDTH,LANE)-1:0]  b_we,
  input  logic [ADDR-1:0]               b_addr,
  input  logic [WIDTH-1:0]              b_din,
  output logic [WIDTH-1:0]              b_dout,
  output logic                          b_valid
);
  localparam int NL = lanes(WIDTH, LANE);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  // a preloaded image must survive reset, so the clear only runs without a file
  localparam bit DO_CLR = CLR_ON_RST && (FILE == "");
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $fatal(1, "bram_tdp_ctrl: RD_LAT must be 1 or 2");
  end
  if (WIDTH % LANE != 0) begin : g_bad_lane
    $fatal(1, "bram_tdp_ctrl: WIDTH must be a multiple of LANE");
  end
  logic [WIDTH-1:0] mem [DEPTH];
  state_t           state_q, state_d;
  logic [AW-1:0]    clr_addr, a_idx, b_idx, a_wa;
  logic             clr, clr_last, a_acc, b_acc, a_ok, b_ok, a_wr, b_wr;
  logic [NL-1:0]    a_wm;
  logic [WIDTH-1:0] a_wd, a_old, b_old, a_new, b_new;
  assign clr = state_q == CLEAR;
  assign clr_last = clr_addr == AW'(DEPTH - 1);
  assign a_acc = a_en && ready;
  assign b_acc = b_en && ready;
  assign a_ok = 32'(a_addr) < DEPTH;
  assign b_ok = 32'(b_addr) < DEPTH;
  assign a_idx = a_addr[AW-1:0];
  assign b_idx = b_addr[AW-1:0];
  // the clear sequencer borrows the port A write path
  assign a_wr = clr || (a_acc && a_ok);
  assign b_wr = b_acc && b_ok;
  assign a_wa = clr ? clr_addr : a_idx;
  assign a_wm = clr ? '1 : a_we;
  assign a_wd = clr ? '0 : a_din;
  assign a_old = mem[a_idx];
  assign b_old = mem[b_idx];
  // own-port merge only: a port never sees the other port's same-edge write
  always_comb begin
    a_new = a_old;
    b_new = b_old;
    for (int k = 0; k < NL; k++) begin
      if (a_we[k]) a_new[k*LANE +: LANE] = a_din[k*LANE +: LANE];
      if (b_we[k]) b_new[k*LANE +: LANE] = b_din[k*LANE +: LANE];
    end
  end
  // A is assigned last so it wins any lane both ports write
  always_ff @(posedge clk)
    for (int k = 0; k < NL; k++) begin
      if (b_wr && b_we[k]) mem[b_idx][k*LANE +: LANE] <= b_din[k*LANE +: LANE];
      if (a_wr && a_wm[k]) mem[a_wa][k*LANE +: LANE] <= a_wd[k*LANE +: LANE];
    end
  always_comb begin
    state_d = state_q == IDLE ? (DO_CLR ? CLEAR : RUN) : (clr && clr_last) ? RUN : state_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      clr_addr <= '0;
      ready <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_addr <= clr ? clr_addr + AW'(1) : '0;
      ready <= state_d == RUN;
    end
  bram_port_pipe #(.RD_LAT(RD_LAT), .WIDTH(WIDTH)) u_pa (
    .clk(clk), .rst(rst), .v_in(a_acc), .oor(!a_ok),
    .d_in(RDW_MODE == RDW_WRITE_FIRST ? a_new : a_old), .dout(a_dout), .valid(a_valid)
  );
  bram_port_pipe #(.RD_LAT(RD_LAT), .WIDTH(WIDTH)) u_pb (
    .clk(clk), .rst(rst), .v_in(b_acc), .oor(!b_ok),
    .d_in(RDW_MODE == RDW_WRITE_FIRST ? b_new : b_old), .dout(b_dout), .valid(b_valid)
  );
endmodule

// File: tb/tb_bram_tdp_ctrl.sv
// tb_bram_tdp_ctrl: directed bench driving a read-first/latency-1/clearing instance and a write-first/latency-2/non-clearing instance in lockstep
module tb_bram_tdp_ctrl;
  localparam int W = 128, D = 16, A = 5, L = 8, N = 16;
  logic clk = 1'b0, rst = 1'b0;
  logic a_en = 1'b0, b_en = 1'b0;
  logic [N-1:0] a_we = '0, b_we = '0;
  logic [A-1:0] a_addr = '0, b_addr = '0;
  logic [W-1:0] a_din = '0, b_din = '0;
  logic r0, r1, a0_v, b0_v, a1_v, b1_v;
  logic [W-1:0] a0_d, b0_d, a1_d, b1_d;
  logic [W-1:0] e, c;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  bram_tdp_ctrl #(.WIDTH(W), .DEPTH(D), .ADDR(A), .LANE(L), .RD_LAT(1), .RDW_MODE(1'b0),
    .CLR_ON_RST(1'b1), .FILE("")) u0 (
    .clk(clk), .rst(rst), .ready(r0),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a0_d), .a_valid(a0_v),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b0_d), .b_valid(b0_v));
  bram_tdp_ctrl #(.WIDTH(W), .DEPTH(D), .ADDR(A), .LANE(L), .RD_LAT(2), .RDW_MODE(1'b1),
    .CLR_ON_RST(1'b0), .FILE("")) u1 (
    .clk(clk), .rst(rst), .ready(r1),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a1_d), .a_valid(a1_v),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b1_d), .b_valid(b1_v));
  function automatic logic [W-1:0] rep(input logic [7:0] b);
    return {16{b}};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    a_en = 1'b0; b_en = 1'b0; a_we = '0; b_we = '0;
  endtask
  task automatic drain;
    idle; tick; tick; tick;
  endtask
  task automatic wr_a(input int ad, input logic [N-1:0] we, input logic [W-1:0] d);
    a_en = 1'b1; a_we = we; a_addr = 5'(ad); a_din = d;
    tick;
    idle;
  endtask
  task automatic test_reset;
    rst = 1'b0;
    tick; tick;
    vecs++; if ({r0, r1} !== 2'b00) begin errs++; $display("FAIL reset_ready got %b exp 00", {r0, r1}); end
    vecs++; if ({a0_v, b0_v, a1_v, b1_v} !== 4'b0) begin errs++; $display("FAIL reset_valid got %b exp 0000", {a0_v, b0_v, a1_v, b1_v}); end
    vecs++; if ({a0_d, b0_d, a1_d, b1_d} !== 512'b0) begin errs++; $display("FAIL reset_dout got %h exp 0", {a0_d, b0_d, a1_d, b1_d}); end
  endtask
  task automatic test_clear;
    rst = 1'b1;
    a_en = 1'b1; a_we = '1; a_addr = 5'd0; a_din = '1;
    for (int i = 1; i <= 17; i++) begin
      tick;
      vecs++; if ({r0, a0_v} !== {i == 17, 1'b0}) begin errs++; $display("FAIL clear_ready edge %0d got %b exp %b", i, {r0, a0_v}, {i == 17, 1'b0}); end
      if (i == 1) begin
        vecs++; if (r1 !== 1'b1) begin errs++; $display("FAIL noclr_ready got %b exp 1", r1); end
      end
    end
    idle;
    for (int i = 0; i < D; i++) begin
      a_en = 1'b1; a_addr = 5'(i);
      tick;
      vecs++; if ({a0_v, a0_d} !== {1'b1, 128'h0}) begin errs++; $display("FAIL clear_rd addr %0d got %h exp %h", i, {a0_v, a0_d}, {1'b1, 128'h0}); end
    end
    idle;
    tick;
    vecs++; if ({a0_v, a0_d} !== {1'b0, 128'h0}) begin errs++; $display("FAIL clear_hold got %h exp %h", {a0_v, a0_d}, {1'b0, 128'h0}); end
    for (int i = 0; i < D; i++) wr_a(i, '1, rep(8'(8'h40 + i)));
    drain;
  endtask
  task automatic test_lane;
    e = {{14{8'h11}}, {2{8'hAB}}};
    wr_a(5, '1, rep(8'h11));
    drain;
    wr_a(5, 16'h0003, rep(8'hAB));
    vecs++; if ({a0_v, a0_d} !== {1'b1, rep(8'h11)}) begin errs++; $display("FAIL lane_wr_old got %h exp %h", {a0_v, a0_d}, {1'b1, rep(8'h11)}); end
    tick;
    vecs++; if ({a1_v, a1_d} !== {1'b1, e}) begin errs++; $display("FAIL lane_wr_new got %h exp %h", {a1_v, a1_d}, {1'b1, e}); end
    tick;
    a_en = 1'b1; a_addr = 5'd5;
    tick;
    idle;
    vecs++; if ({a0_v, a0_d} !== {1'b1, e}) begin errs++; $display("FAIL lane_rd_l1 got %h exp %h", {a0_v, a0_d}, {1'b1, e}); end
    vecs++; if (a1_v !== 1'b0) begin errs++; $display("FAIL lane_l2_early got %b exp 0", a1_v); end
    tick;
    vecs++; if ({a0_v, a0_d} !== {1'b0, e}) begin errs++; $display("FAIL lane_l1_hold got %h exp %h", {a0_v, a0_d}, {1'b0, e}); end
    vecs++; if ({a1_v, a1_d} !== {1'b1, e}) begin errs++; $display("FAIL lane_rd_l2 got %h exp %h", {a1_v, a1_d}, {1'b1, e}); end
    tick;
    vecs++; if (a1_v !== 1'b0) begin errs++; $display("FAIL lane_l2_once got %b exp 0", a1_v); end
  endtask
  task automatic test_rdw;
    wr_a(3, '1, 128'h1);
    drain;
    wr_a(3, '1, 128'h2);
    vecs++; if ({a0_v, a0_d} !== {1'b1, 128'h1}) begin errs++; $display("FAIL rdw_read_first got %h exp %h", {a0_v, a0_d}, {1'b1, 128'h1}); end
    tick;
    vecs++; if ({a1_v, a1_d} !== {1'b1, 128'h2}) begin errs++; $display("FAIL rdw_write_first got %h exp %h", {a1_v, a1_d}, {1'b1, 128'h2}); end
    drain;
  endtask
  task automatic test_collision;
    c = {{13{8'h11}}, 8'hBB, 8'hAA, 8'hAA};
    wr_a(7, '1, rep(8'h11));
    drain;
    a_en = 1'b1; a_we = 16'h0003; a_addr = 5'd7; a_din = rep(8'hAA);
    b_en = 1'b1; b_we = 16'h0006; b_addr = 5'd7; b_din = rep(8'hBB);
    tick;
    idle;
    vecs++; if ({a0_v, a0_d, b0_v, b0_d} !== {1'b1, rep(8'h11), 1'b1, rep(8'h11)}) begin errs++; $display("FAIL coll_old got %h exp %h", {a0_v, a0_d, b0_v, b0_d}, {1'b1, rep(8'h11), 1'b1, rep(8'h11)}); end
    tick;
    e = {{13{8'h11}}, 8'hBB, 8'hBB, 8'h11};
    vecs++; if ({a1_v, a1_d, b1_v, b1_d} !== {1'b1, {{14{8'h11}}, 8'hAA, 8'hAA}, 1'b1, e}) begin errs++; $display("FAIL coll_own_merge got %h exp %h", {a1_v, a1_d, b1_v, b1_d}, {1'b1, {{14{8'h11}}, 8'hAA, 8'hAA}, 1'b1, e}); end
    tick;
    a_en = 1'b1; a_addr = 5'd7;
    tick;
    idle;
    vecs++; if ({a0_v, a0_d} !== {1'b1, c}) begin errs++; $display("FAIL coll_merge got %h exp %h", {a0_v, a0_d}, {1'b1, c}); end
    drain;
    a_en = 1'b1; a_we = '1; a_addr = 5'd7; a_din = rep(8'hCC);
    b_en = 1'b1; b_addr = 5'd7;
    tick;
    idle;
    vecs++; if ({b0_v, b0_d} !== {1'b1, c}) begin errs++; $display("FAIL cross_rd_l1 got %h exp %h", {b0_v, b0_d}, {1'b1, c}); end
    tick;
    vecs++; if ({b1_v, b1_d, a1_d} !== {1'b1, c, rep(8'hCC)}) begin errs++; $display("FAIL cross_rd_l2 got %h exp %h", {b1_v, b1_d, a1_d}, {1'b1, c, rep(8'hCC)}); end
    tick;
    b_en = 1'b1; b_addr = 5'd7;
    tick;
    idle;
    vecs++; if ({b0_v, b0_d} !== {1'b1, rep(8'hCC)}) begin errs++; $display("FAIL cross_after got %h exp %h", {b0_v, b0_d}, {1'b1, rep(8'hCC)}); end
    drain;
  endtask
  task automatic test_back_to_back;
    for (int t = 0; t <= 8; t++) begin
      if (t < 8) begin
        a_en = 1'b1; a_we = '0; a_addr = 5'(8 + t);
        b_en = 1'b1; b_we = '1; b_addr = 5'(t); b_din = rep(8'(8'h80 + t));
      end else idle;
      tick;
      e = rep(8'(8'h40 + 8 + (t < 8 ? t : 7)));
      vecs++; if ({a0_v, a0_d} !== {t < 8, e}) begin errs++; $display("FAIL stream_l1 t%0d got %h exp %h", t, {a0_v, a0_d}, {t < 8, e}); end
      if (t == 0) begin
        vecs++; if (a1_v !== 1'b0) begin errs++; $display("FAIL stream_l2 t0 got %b exp 0", a1_v); end
      end else begin
        e = rep(8'(8'h40 + 8 + t - 1));
        vecs++; if ({a1_v, a1_d} !== {1'b1, e}) begin errs++; $display("FAIL stream_l2 t%0d got %h exp %h", t, {a1_v, a1_d}, {1'b1, e}); end
      end
    end
    tick;
    for (int i = 0; i < 8; i++) begin
      b_en = 1'b1; b_addr = 5'(i);
      tick;
      vecs++; if ({b0_v, b0_d} !== {1'b1, rep(8'(8'h80 + i))}) begin errs++; $display("FAIL stream_wr addr %0d got %h exp %h", i, {b0_v, b0_d}, {1'b1, rep(8'(8'h80 + i))}); end
    end
    drain;
  endtask
  task automatic test_oor;
    wr_a(20, '1, '1);
    vecs++; if ({a0_v, a0_d} !== {1'b1, 128'h0}) begin errs++; $display("FAIL oor_wr_l1 got %h exp %h", {a0_v, a0_d}, {1'b1, 128'h0}); end
    tick;
    vecs++; if ({a1_v, a1_d} !== {1'b1, 128'h0}) begin errs++; $display("FAIL oor_wr_l2 got %h exp %h", {a1_v, a1_d}, {1'b1, 128'h0}); end
    tick;
    a_en = 1'b1; a_addr = 5'd4;
    tick;
    vecs++; if ({a0_v, a0_d} !== {1'b1, rep(8'h84)}) begin errs++; $display("FAIL oor_alias got %h exp %h", {a0_v, a0_d}, {1'b1, rep(8'h84)}); end
    a_addr = 5'd20;
    tick;
    idle;
    vecs++; if ({a0_v, a0_d, a1_v, a1_d} !== {1'b1, 128'h0, 1'b1, rep(8'h84)}) begin errs++; $display("FAIL oor_rd_l1 got %h exp %h", {a0_v, a0_d, a1_v, a1_d}, {1'b1, 128'h0, 1'b1, rep(8'h84)}); end
    tick;
    vecs++; if ({a1_v, a1_d} !== {1'b1, 128'h0}) begin errs++; $display("FAIL oor_rd_l2 got %h exp %h", {a1_v, a1_d}, {1'b1, 128'h0}); end
    drain;
  endtask
  task automatic test_rst_mid;
    a_en = 1'b1; a_addr = 5'd1;
    tick;
    a_addr = 5'd2;
    tick;
    idle;
    rst = 1'b0;
    #1;
    vecs++; if ({a0_v, a1_v, b0_v, b1_v, r0, r1} !== 6'b0) begin errs++; $display("FAIL rst_async got %b exp 000000", {a0_v, a1_v, b0_v, b1_v, r0, r1}); end
    tick; tick;
    rst = 1'b1;
    tick;
    vecs++; if ({r0, r1, a0_v, a1_v} !== 4'b0100) begin errs++; $display("FAIL rst_release got %b exp 0100", {r0, r1, a0_v, a1_v}); end
    for (int i = 2; i <= 17; i++) begin
      tick;
      vecs++; if ({r0, a0_v, a1_v} !== {i == 17, 2'b00}) begin errs++; $display("FAIL rst_reclear edge %0d got %b exp %b", i, {r0, a0_v, a1_v}, {i == 17, 2'b00}); end
    end
    a_en = 1'b1; a_addr = 5'd1;
    tick;
    idle;
    vecs++; if ({a0_v, a0_d} !== {1'b1, 128'h0}) begin errs++; $display("FAIL rst_recleared got %h exp %h", {a0_v, a0_d}, {1'b1, 128'h0}); end
    tick;
    vecs++; if ({a1_v, a1_d} !== {1'b1, rep(8'h81)}) begin errs++; $display("FAIL rst_kept got %h exp %h", {a1_v, a1_d}, {1'b1, rep(8'h81)}); end
    tick;
  endtask
  initial begin
    test_reset;
    test_clear;
    test_lane;
    test_rdw;
    test_collision;
    test_back_to_back;
    test_oor;
    test_rst_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
